// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a two-flop input synchroniser, mid-bit sampling and one-cycle result strobes.
// The default build uses 8N1 framing. Defining UART_RX_PARITY_EN adds a parity bit checked against PARITY_ODD.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY  = 3'd3;
`endif
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_CLEANUP = 3'd5;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_MID  = 16'((CLKS_PER_BIT - 1) / 2);

    logic        r_rx_meta;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [15:0] r_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_dv;
    logic [7:0]  r_byte;
    logic        r_active;
    logic        r_ferr;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bad;
    logic        r_perr;
`else
    logic        w_unused_parity_odd;
`endif

    logic        w_at_last;
    logic        w_at_mid;

    assign w_at_last = (r_count == LP_LAST);
    assign w_at_mid  = (r_count == LP_MID);

    // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_dv      <= 1'b0;
            r_byte    <= 8'h00;
            r_active  <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_dv   <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_count   <= 16'd0;
                    r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                    if (!r_rx_s) begin
                        r_state  <= S_START;
                        r_active <= 1'b1;
                    end
                end

                // A start bit that is no longer low at its midpoint was a glitch.
                S_START: begin
                    if (w_at_mid) begin
                        r_count <= 16'd0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_at_last) begin
                        r_count            <= 16'd0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_at_last) begin
                        r_count   <= 16'd0;
                        r_par_bad <= (r_rx_s != ((^r_shift) ^ PARITY_ODD));
                        r_state   <= S_STOP;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
`endif

                // A low stop bit wins over any latched parity mismatch.
                S_STOP: begin
                    if (w_at_last) begin
                        r_count <= 16'd0;
                        r_state <= S_CLEANUP;
                        if (!r_rx_s) begin
                            r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_perr <= 1'b1;
`endif
                        end else begin
                            r_byte <= r_shift;
                            r_dv   <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

                // Wait out a break so a line held low is not taken as a new start bit.
                S_CLEANUP: begin
                    r_count <= 16'd0;
                    if (r_rx_s) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_count   <= 16'd0;
                    r_bit_idx <= 3'd0;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Byte   = r_byte;
    assign o_Rx_Active = r_active;
    assign o_Frame_Err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = r_perr;
`else
    assign o_Parity_Err        = 1'b0;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal serial frames are driven in, and the received bytes and strobes are compared against a queue model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB  = 8;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int EXP_LAT = ((2 * FRAME_BITS - 1) * CPB) / 2 + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       ferr;
    logic       perr;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_Rx_Serial  (rx),
        .o_Rx_DV      (dv),
        .o_Rx_Byte    (rx_byte),
        .o_Rx_Active  (active),
        .o_Frame_Err  (ferr),
        .o_Parity_Err (perr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, multi_cnt = 0, rise_cnt = 0;
    int dv_cyc = 0, rise_cyc = 0, fall_cyc = 0, start_cyc = 0;
    logic act_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Observer: records strobes and activity edges away from the active clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dv) begin
            got_q.push_back(rx_byte);
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (ferr) fe_cnt = fe_cnt + 1;
        if (perr) pe_cnt = pe_cnt + 1;
        if (int'(dv) + int'(ferr) + int'(perr) > 1) multi_cnt = multi_cnt + 1;
        if (active && !act_prev) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        if (!active && act_prev) fall_cyc = cyc;
        act_prev = active;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ PODD ^ par_flip);
`endif
        drive_bit(stop);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", dv); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", rx_byte); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if ({ferr, perr} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {ferr, perr}); end
        rst_n = 1'b1;
        idle_bits(2);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b expected 0", active); end
    endtask

    task automatic test_basic;
        int dv0, fe0, pe0, r0, dur, lat;
        dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt; r0 = rise_cnt;
        got_q.delete();
        send_frame(8'hA5, 1'b1);
        last_good = 8'hA5;
        idle_bits(2);
        dur = fall_cyc - rise_cyc;
        lat = dv_cyc - start_cyc;
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - dv0); end
        checks++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h expected a5", rx_byte); end
        checks++; if (fe_cnt - fe0 + pe_cnt - pe0 !== 0) begin errors++; $display("FAIL basic_err: got %0d error strobes expected 0", fe_cnt - fe0 + pe_cnt - pe0); end
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL basic_active_rises: got %0d expected 1", rise_cnt - r0); end
        checks++; if (dur < (FRAME_BITS - 1) * CPB || dur > FRAME_BITS * CPB) begin
            errors++; $display("FAIL basic_active_len: got %0d cycles expected %0d..%0d", dur, (FRAME_BITS - 1) * CPB, FRAME_BITS * CPB);
        end
        checks++; if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d +/-2", lat, EXP_LAT); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL basic_hold: got %h expected a5", rx_byte); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        int fe0;
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        fe0 = fe_cnt;
        got_q.delete();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1);
        last_good = 8'h3C;
        idle_bits(2);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== seq[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], seq[i]); end
        end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL b2b_ferr: got %0d expected %0d", fe_cnt, fe0); end
    endtask

    task automatic test_glitch;
        int dv0, fe0, pe0, r0;
        dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt; r0 = rise_cnt;
        @(negedge clk); rx = 1'b0;
        @(negedge clk);
        @(negedge clk); rx = 1'b1;
        idle_bits(3);
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL glitch_dv: got %0d expected %0d", dv_cnt, dv0); end
        checks++; if (fe_cnt + pe_cnt !== fe0 + pe0) begin errors++; $display("FAIL glitch_err: got %0d expected %0d", fe_cnt + pe_cnt, fe0 + pe0); end
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL glitch_active_pulse: got %0d rises expected 1", rise_cnt - r0); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL glitch_active_clear: got %b expected 0", active); end
    endtask

    task automatic test_frame_err;
        int dv0, fe0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        got_q.delete();
        send_frame(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL ferr_break_active: got %b expected 1", active); end
        rx = 1'b1;
        idle_bits(2);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0); end
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL ferr_no_dv: got %0d expected %0d", dv_cnt, dv0); end
        checks++; if (rx_byte !== last_good) begin errors++; $display("FAIL ferr_byte_hold: got %h expected %h", rx_byte, last_good); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL ferr_active_clear: got %b expected 0", active); end
        send_frame(8'h12, 1'b1);
        last_good = 8'h12;
        idle_bits(2);
        checks++; if (got_q.size() !== 1 || rx_byte !== 8'h12) begin
            errors++; $display("FAIL ferr_recover: got %0d bytes, byte %h expected 1 byte 12", got_q.size(), rx_byte);
        end
    endtask

    task automatic test_reset_midframe;
        int dv0, fe0, pe0;
        dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        got_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b1 : 1'b0);
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; rx = 1'b1;
        #1;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rstmid_active: got %b expected 0", active); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h expected 00", rx_byte); end
        checks++; if ({dv, ferr, perr} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes: got %b expected 000", {dv, ferr, perr}); end
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2 * FRAME_BITS);
        checks++; if (dv_cnt + fe_cnt + pe_cnt !== dv0 + fe0 + pe0) begin
            errors++; $display("FAIL rstmid_no_strobe: got %0d strobes expected %0d", dv_cnt + fe_cnt + pe_cnt, dv0 + fe0 + pe0);
        end
        send_frame(8'h81, 1'b1);
        last_good = 8'h81;
        idle_bits(2);
        checks++; if (got_q.size() !== 1 || rx_byte !== 8'h81) begin
            errors++; $display("FAIL rstmid_recover: got %0d bytes, byte %h expected 1 byte 81", got_q.size(), rx_byte);
        end
    endtask

    task automatic test_random;
        int fe0, exp_fe;
        logic [7:0] b;
        logic bad;
        fe0 = fe_cnt; exp_fe = 0;
        got_q.delete(); exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, !bad);
            if (bad) begin
                exp_fe++;
                idle_bits(1 + $urandom_range(0, 1));
            end else begin
                exp_q.push_back(b);
                last_good = b;
                idle_bits($urandom_range(0, 2));
            end
        end
        idle_bits(2);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (fe_cnt - fe0 !== exp_fe) begin errors++; $display("FAIL rand_ferr: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
        checks++; if (rx_byte !== last_good) begin errors++; $display("FAIL rand_last_byte: got %h expected %h", rx_byte, last_good); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int dv0, pe0;
        got_q.delete();
        send_frame(8'h07, 1'b1);
        last_good = 8'h07;
        idle_bits(2);
        checks++; if (got_q.size() !== 1 || rx_byte !== 8'h07) begin
            errors++; $display("FAIL par_good: got %0d bytes, byte %h expected 1 byte 07", got_q.size(), rx_byte);
        end
        dv0 = dv_cnt; pe0 = pe_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        idle_bits(2);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL par_err_count: got %0d expected 1", pe_cnt - pe0); end
        checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL par_no_dv: got %0d expected %0d", dv_cnt, dv0); end
        checks++; if (rx_byte !== 8'h07) begin errors++; $display("FAIL par_byte_hold: got %h expected 07", rx_byte); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", multi_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the downstream peer of the team's 8N1 transmitter, sharing its CLKS_PER_BIT timing (default 434, i.e. 50 MHz / 115200).
- Synchronises the asynchronous RX line, detects and qualifies the start bit, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit, then presents the byte with a one-cycle valid strobe to the consuming logic (command parser or RX FIFO).

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit; legal range 4..65535.
- PARITY_ODD, 0, used only with the optional feature: 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_Rx_Serial  in  1  asynchronous serial line; idle high.
- o_Rx_DV  out  1  one-cycle strobe; o_Rx_Byte is valid in this cycle.
- o_Rx_Byte  out  8  last correctly received byte.
- o_Rx_Active  out  1  high while a frame is being received.
- o_Frame_Err  out  1  one-cycle strobe when the stop bit is sampled low.
- o_Parity_Err  out  1  one-cycle strobe on parity mismatch; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n is low, all state clears immediately:
  - state = IDLE; 16-bit counter and 3-bit bit index = 0.
  - Synchroniser flops = 1.
  - o_Rx_DV = 0, o_Rx_Byte = 8'h00, o_Rx_Active = 0, o_Frame_Err = 0, o_Parity_Err = 0.
  - Reset mid-frame abandons the frame; no strobe is emitted.
- Synchroniser: two flops on i_Rx_Serial. All logic below uses only the second flop (rx_s).
- States: IDLE, START, DATA, PARITY (feature only), STOP, CLEANUP.
- IDLE:
  - counter = 0, bit index = 0.
  - rx_s == 0 -> START, set o_Rx_Active.
- START:
  - Counter increments until it reaches (CLKS_PER_BIT-1)/2 (integer division), i.e. mid start bit.
  - At that point: rx_s == 0 -> counter = 0, go to DATA. rx_s == 1 -> glitch; go to IDLE and clear o_Rx_Active.
- DATA:
  - At counter == CLKS_PER_BIT-1, sample rx_s into shift register bit [bit index] and set counter = 0. Otherwise counter increments.
  - After bit index 7, go to PARITY if the feature is compiled in, else STOP. The bit index wraps to 0.
- STOP: at counter == CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1: o_Rx_Byte <= shift register; o_Rx_DV = 1 for exactly one cycle, unless a parity error was latched (see Optional Feature).
  - rx_s == 0: o_Frame_Err = 1 for one cycle; o_Rx_Byte unchanged; no DV.
  - Then go to CLEANUP.
- CLEANUP:
  - Stay until rx_s == 1. This takes one cycle for a valid stop bit; for a break or line held low, hold here until the line returns high. This prevents false starts.
  - Then go to IDLE and clear o_Rx_Active.
- Latency: DV rises about 9.5 bit periods + 3 clk after the falling edge of the start bit. DV and the byte update occur in the same cycle.
- o_Rx_Byte holds its value between strobes. Only one of DV / Frame_Err / Parity_Err is high in any cycle.
- Back-to-back frames: a start edge arriving after the mid-stop sample (or the cleanup exit) must be captured. Zero idle bits between frames is legal.
- Illegal state encodings -> IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8 data + 1 parity + 1 stop.
  - PARITY state samples the bit at counter == CLKS_PER_BIT-1 and compares it to XOR(data) ^ PARITY_ODD.
  - A mismatch is latched. At the STOP sample with stop == 1, the latch produces a one-cycle o_Parity_Err instead of o_Rx_DV, and o_Rx_Byte is not updated.
  - A frame error takes precedence over a parity error.
- Undefined: no PARITY state; 8N1 framing; o_Parity_Err is constant 0.

Test Plan:
- CLKS_PER_BIT=8, drive an ideal 8N1 frame for 0xA5 -> single o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Active high for the whole frame, no error strobes.
- Loopback from the team's transmitter (same CLKS_PER_BIT) sending 0x00, 0xFF, 0x3C back-to-back -> three DV pulses with bytes 0x00, 0xFF, 0x3C in order, none dropped.
- Low glitch of 2 clk on the idle line (CLKS_PER_BIT=8) -> returns to IDLE, no DV, no errors, o_Rx_Active pulses briefly and then clears.
- Frame 0x55 with the stop bit driven low, line held low for 3 bit times, then high -> o_Frame_Err one cycle; o_Rx_Byte keeps its previous value; no DV until a new valid frame (0x12) yields DV with byte 0x12.
- rst_n pulsed low in the middle of data bit 4 of frame 0x81 -> all outputs reset at once, no strobes; the next full frame 0x81 is received correctly.
- UART_RX_PARITY_EN with PARITY_ODD=0:
  - 0x07 sent with parity 1 -> DV, byte 0x07.
  - Same frame with parity 0 -> o_Parity_Err one cycle, no DV, byte stays 0x07.
